spi_controller: RTL and testbench

SPI controller that originates the 16-bit, mode-0 write frames consumed by the on-chip SPI peripheral driving the PWM registers. The block takes a request (write flag, 7-bit address, 8-bit data) over a valid/ready handshake and serialises it MSB-first on `ncs`/`sclk`/`copi`. A `done` pulse marks frame completion. It sits between the test/control logic and the SPI pins, or loops back to the peripheral in system benches.

---
 rtl/spi_controller_if.sv | 21 ++
 rtl/spi_controller.sv | 158 +++++++++++++++
 tb/tb_spi_controller.sv | 380 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_controller_if.sv
// Request/status bundle between the requester and spi_controller.
// master drives requests; slave (the controller) returns ready/busy/done.
interface spi_controller_if;
    logic       req_valid;
    logic       req_ready;
    logic       req_write;
    logic [6:0] req_addr;
    logic [7:0] req_data;
    logic       busy;
    logic       done;

    modport master (
        output req_valid, req_write, req_addr, req_data,
        input  req_ready, busy, done
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_data,
        output req_ready, busy, done
    );
endinterface

// File: rtl/spi_controller.sv
// SPI mode-0 (CPOL=0) 16-bit write-frame originator, MSB first.
// Define SPI_CTRL_READBACK_EN to add cipo capture into rsp_data.
module spi_controller #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic             clk,
    input  logic             rst,
    spi_controller_if.slave  req,
    output logic             ncs,
    output logic             sclk,
    output logic             copi
`ifdef SPI_CTRL_READBACK_EN
    ,
    input  logic             cipo,
    output logic [7:0]       rsp_data
`endif
);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

    localparam logic [7:0] DIV_LAST  = 8'(CLK_DIV - 1);
    localparam logic [7:0] DIV_READY = 8'(CLK_DIV - 2);

    state_t      state, state_nxt;
    logic [7:0]  div_cnt, div_nxt;
    logic [3:0]  bit_cnt, bit_nxt;
    logic [15:0] shreg, shreg_nxt;
    logic        ncs_nxt, sclk_nxt, copi_nxt;
    logic        ready_nxt, busy_nxt, done_nxt;
    logic        div_end;

`ifdef SPI_CTRL_READBACK_EN
    logic [7:0]  cap, cap_nxt;
    logic [7:0]  rsp_nxt;
`endif

    assign div_end = (div_cnt == DIV_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            div_cnt       <= '0;
            bit_cnt       <= '0;
            shreg         <= '0;
            ncs           <= 1'b1;
            sclk          <= 1'b0;
            copi          <= 1'b0;
            req.req_ready <= 1'b0;
            req.busy      <= 1'b0;
            req.done      <= 1'b0;
`ifdef SPI_CTRL_READBACK_EN
            cap           <= '0;
            rsp_data      <= '0;
`endif
        end else begin
            state         <= state_nxt;
            div_cnt       <= div_nxt;
            bit_cnt       <= bit_nxt;
            shreg         <= shreg_nxt;
            ncs           <= ncs_nxt;
            sclk          <= sclk_nxt;
            copi          <= copi_nxt;
            req.req_ready <= ready_nxt;
            req.busy      <= busy_nxt;
            req.done      <= done_nxt;
`ifdef SPI_CTRL_READBACK_EN
            cap           <= cap_nxt;
            rsp_data      <= rsp_nxt;
`endif
        end
    end

    // shreg holds the bits still to be sent after the one currently on copi.
    always_comb begin
        state_nxt = state;
        div_nxt   = div_cnt + 8'd1;
        bit_nxt   = bit_cnt;
        shreg_nxt = shreg;
        ncs_nxt   = ncs;
        sclk_nxt  = sclk;
        copi_nxt  = copi;
        ready_nxt = req.req_ready;
        busy_nxt  = req.busy;
        done_nxt  = 1'b0;
`ifdef SPI_CTRL_READBACK_EN
        cap_nxt   = cap;
        rsp_nxt   = rsp_data;
`endif

        case (state)
            IDLE: begin
                div_nxt   = '0;
                ready_nxt = 1'b1;
                if (req.req_valid && req.req_ready) begin
                    shreg_nxt = {req.req_addr, req.req_data, 1'b0};
                    copi_nxt  = req.req_write;
                    ncs_nxt   = 1'b0;
                    busy_nxt  = 1'b1;
                    ready_nxt = 1'b0;
                    bit_nxt   = '0;
                    state_nxt = SETUP;
                end
            end
            SETUP: begin
                if (div_end) begin
                    div_nxt   = '0;
                    sclk_nxt  = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (div_end) begin
                    div_nxt = '0;
                    if (!sclk) begin
                        sclk_nxt = 1'b1;
                    end else begin
                        sclk_nxt = 1'b0;
`ifdef SPI_CTRL_READBACK_EN
                        if (bit_cnt[3])
                            cap_nxt = {cap[6:0], cipo};
`endif
                        if (bit_cnt == 4'd15) begin
                            copi_nxt  = 1'b0;
                            state_nxt = HOLD;
                        end else begin
                            copi_nxt  = shreg[15];
                            shreg_nxt = {shreg[14:0], 1'b0};
                            bit_nxt   = bit_cnt + 4'd1;
                        end
                    end
                end
            end
            HOLD: begin
                if (div_end) begin
                    div_nxt   = '0;
                    ncs_nxt   = 1'b1;
                    done_nxt  = 1'b1;
                    state_nxt = GAP;
`ifdef SPI_CTRL_READBACK_EN
                    rsp_nxt   = cap;
`endif
                end
            end
            GAP: begin
                // Ready is raised for the last gap cycle so a held request
                // is accepted exactly 34*CLK_DIV cycles after the previous one.
                if (div_cnt == DIV_READY) begin
                    div_nxt   = '0;
                    ready_nxt = 1'b1;
                    busy_nxt  = 1'b0;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_spi_controller.sv
// Self-checking bench for spi_controller: a pin-level monitor decodes frames,
// edge times and a PWM register file; tasks compare against spec timing.
module tb_spi_controller;

    localparam int N = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ncs, sclk, copi;
    spi_controller_if ifc ();

`ifdef SPI_CTRL_READBACK_EN
    logic       cipo = 1'b0;
    logic [7:0] rsp_data;
    logic [7:0] resp_val = 8'h00;
`endif

    spi_controller #(.CLK_DIV(N)) dut (
        .clk  (clk),
        .rst  (rst),
        .req  (ifc),
        .ncs  (ncs),
        .sclk (sclk),
        .copi (copi)
`ifdef SPI_CTRL_READBACK_EN
        ,
        .cipo     (cipo),
        .rsp_data (rsp_data)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    int          rise_q[$];
    int          fall_q[$];
    int          ncsf_q[$];
    int          ncsr_q[$];
    int          done_q[$];
    logic [15:0] frame_q[$];
    int          ready_rise = -1;
    int          copi_viol = 0;
    logic [7:0]  pwm [0:127];

    logic        p_ncs = 1'b1, p_sclk = 1'b0, p_copi = 1'b0, p_ready = 1'b0;
    int          nbits = 0;
    logic [15:0] shv = '0;

    // Pin-level observer sampled 1 time unit after each rising edge.
    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        if (!ncs && p_ncs) begin
            ncsf_q.push_back(cyc);
            nbits = 0;
            shv = '0;
        end
        if (sclk && !p_sclk) begin
            rise_q.push_back(cyc);
            shv = {shv[14:0], copi};
            nbits++;
`ifdef SPI_CTRL_READBACK_EN
            if (nbits >= 9) cipo = resp_val[16 - nbits];
`endif
        end
        if (!sclk && p_sclk) fall_q.push_back(cyc);
        if (sclk && copi !== p_copi) copi_viol++;
        if (ncs && !p_ncs) begin
            ncsr_q.push_back(cyc);
            if (nbits == 16) begin
                frame_q.push_back(shv);
                if (shv[15]) pwm[shv[14:8]] = shv[7:0];
            end
            nbits = 0;
        end
        if (ifc.done) done_q.push_back(cyc);
        if (ifc.req_ready && !p_ready) ready_rise = cyc;
        p_ncs = ncs; p_sclk = sclk; p_copi = copi; p_ready = ifc.req_ready;
    end

    task automatic clear_mon();
        rise_q.delete(); fall_q.delete(); ncsf_q.delete(); ncsr_q.delete();
        done_q.delete(); frame_q.delete();
        ready_rise = -1;
        copi_viol = 0;
    endtask

    task automatic send(input logic [15:0] f, input bit hold, output int e0);
        int t;
        t = 0;
        @(negedge clk);
        ifc.req_write = f[15];
        ifc.req_addr  = f[14:8];
        ifc.req_data  = f[7:0];
        ifc.req_valid = 1'b1;
        while (!ifc.req_ready && t < 400) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (!ifc.req_ready) begin
            errors++;
            $display("FAIL accept_timeout: req_ready=%b after %0d cycles, required 1", ifc.req_ready, t);
        end
        e0 = cyc + 1;
        @(posedge clk);
        @(negedge clk);
        if (!hold) ifc.req_valid = 1'b0;
    endtask

    task automatic wait_done(input int n_before);
        int t;
        t = 0;
        while (done_q.size() <= n_before && t < 400) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (done_q.size() <= n_before) begin
            errors++;
            $display("FAIL done_timeout: done count %0d, required > %0d", done_q.size(), n_before);
        end
    endtask

    function automatic logic [15:0] frame_at(input int i);
        return (frame_q.size() > i) ? frame_q[i] : 16'hxxxx;
    endfunction

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({ncs, sclk, copi, ifc.req_ready, ifc.busy, ifc.done} !== 6'b100000) begin
            errors++;
            $display("FAIL reset_outputs: ncs,sclk,copi,ready,busy,done=%b required 100000",
                     {ncs, sclk, copi, ifc.req_ready, ifc.busy, ifc.done});
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (ifc.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: got %b required 1", ifc.req_ready);
        end
    endtask

    task automatic test_frame();
        int e0, bad;
        clear_mon();
        send(16'h80A5, 1'b0, e0);
        checks++;
        if ({ifc.busy, ifc.req_ready} !== 2'b10) begin
            errors++;
            $display("FAIL inflight_busy_ready: busy,ready=%b required 10", {ifc.busy, ifc.req_ready});
        end
        wait_done(0);
        repeat (8) @(negedge clk);
        checks++;
        if (frame_at(0) !== 16'h80A5) begin
            errors++;
            $display("FAIL frame_decode: got %h required 80a5", frame_at(0));
        end
        bad = 0;
        if (rise_q.size() != 16) bad = 99;
        else for (int k = 0; k < 16; k++) if (rise_q[k] != e0 + (2*k+1)*N) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL sclk_rise_times: %0d bad of %0d rises, required 0 bad of 16", bad, rise_q.size());
        end
        checks++;
        if (fall_q.size() == 0 || fall_q[fall_q.size()-1] != e0 + 32*N) begin
            errors++;
            $display("FAIL last_fall: got %0d required %0d", fall_q.size() ? fall_q[fall_q.size()-1] - e0 : -1, 32*N);
        end
        checks++;
        if (ncsf_q.size() != 1 || ncsr_q.size() != 1 || ncsf_q[0] != e0 || ncsr_q[0] - ncsf_q[0] != 132) begin
            errors++;
            $display("FAIL ncs_low_window: falls %0d rises %0d, required ncs low 132 cycles from E0", ncsf_q.size(), ncsr_q.size());
        end
        checks++;
        if (done_q.size() != 1 || done_q[0] != e0 + 132) begin
            errors++;
            $display("FAIL done_time: count %0d offset %0d, required 1 at 132", done_q.size(), done_q.size() ? done_q[0] - e0 : -1);
        end
        checks++;
        if (ready_rise + 1 != e0 + 136) begin
            errors++;
            $display("FAIL ready_time: ready sampled at %0d required %0d", ready_rise + 1 - e0, 136);
        end
        checks++;
        if (copi_viol != 0) begin
            errors++;
            $display("FAIL copi_stability: %0d changes while sclk high, required 0", copi_viol);
        end
        checks++;
        if (ifc.busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_after_frame: got %b required 0", ifc.busy);
        end
    endtask

    task automatic test_back_to_back();
        int e0a, e0b;
        clear_mon();
        send(16'h8180, 1'b1, e0a);
        send(16'h82FF, 1'b0, e0b);
        wait_done(1);
        repeat (4) @(negedge clk);
        checks++;
        if (e0b - e0a != 34*N) begin
            errors++;
            $display("FAIL b2b_period: got %0d required %0d", e0b - e0a, 34*N);
        end
        checks++;
        if (ncsf_q.size() < 2 || ncsr_q.size() < 1 || ncsf_q[1] - ncsr_q[0] != N) begin
            errors++;
            $display("FAIL b2b_ncs_gap: got %0d required %0d",
                     (ncsf_q.size() > 1 && ncsr_q.size() > 0) ? ncsf_q[1] - ncsr_q[0] : -1, N);
        end
        checks++;
        if (frame_at(0) !== 16'h8180 || frame_at(1) !== 16'h82FF) begin
            errors++;
            $display("FAIL b2b_frames: got %h %h required 8180 82ff", frame_at(0), frame_at(1));
        end
    endtask

    task automatic test_loopback();
        int e0;
        clear_mon();
        send(16'h8040, 1'b0, e0);
        wait_done(0);
        checks++;
        if (pwm[0] !== 8'h40) begin
            errors++;
            $display("FAIL pwm0: got %h required 40", pwm[0]);
        end
        send(16'h81C0, 1'b0, e0);
        wait_done(1);
        checks++;
        if (pwm[1] !== 8'hC0 || pwm[0] !== 8'h40) begin
            errors++;
            $display("FAIL pwm1: got pwm0=%h pwm1=%h required 40 c0", pwm[0], pwm[1]);
        end
    endtask

    task automatic test_reset_mid();
        int e0;
        logic [15:0] f;
        clear_mon();
        f = 16'($urandom);
        send(f, 1'b0, e0);
        while (cyc < e0 + 49) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({ncs, sclk, copi, ifc.busy, ifc.done, ifc.req_ready} !== 6'b100000) begin
            errors++;
            $display("FAIL midreset_outputs: ncs,sclk,copi,busy,done,ready=%b required 100000",
                     {ncs, sclk, copi, ifc.busy, ifc.done, ifc.req_ready});
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (ifc.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL midreset_ready: got %b required 1", ifc.req_ready);
        end
        repeat (10) @(negedge clk);
        checks++;
        if (done_q.size() != 0 || frame_q.size() != 0) begin
            errors++;
            $display("FAIL midreset_no_done: done %0d frames %0d required 0 0", done_q.size(), frame_q.size());
        end
        send(16'h8311, 1'b0, e0);
        wait_done(0);
        checks++;
        if (frame_at(0) !== 16'h8311 || done_q[0] != e0 + 132) begin
            errors++;
            $display("FAIL midreset_fresh_frame: got %h required 8311 at 132", frame_at(0));
        end
    endtask

    task automatic test_ignore();
        int e0;
        logic [15:0] f1, f2;
        clear_mon();
        f1 = 16'($urandom);
        f2 = ~f1;
        send(f1, 1'b0, e0);
        while (cyc < e0 + 40) @(negedge clk);
        ifc.req_write = f2[15]; ifc.req_addr = f2[14:8]; ifc.req_data = f2[7:0];
        ifc.req_valid = 1'b1;
        @(negedge clk);
        ifc.req_valid = 1'b0;
        wait_done(0);
        repeat (20) @(negedge clk);
        checks++;
        if (frame_at(0) !== f1 || frame_q.size() != 1 || ncsf_q.size() != 1 || copi_viol != 0) begin
            errors++;
            $display("FAIL ignore_midframe: got %h frames %0d ncs_falls %0d viol %0d required %h 1 1 0",
                     frame_at(0), frame_q.size(), ncsf_q.size(), copi_viol, f1);
        end
    endtask

    task automatic test_random();
        int e0;
        logic [15:0] f;
        for (int i = 0; i < 6; i++) begin
            clear_mon();
            repeat ($urandom_range(0, 5)) @(negedge clk);
            f = 16'($urandom);
            send(f, 1'b0, e0);
            wait_done(0);
            checks++;
            if (frame_at(0) !== f || done_q[0] - e0 != 33*N || rise_q.size() != 16) begin
                errors++;
                $display("FAIL random_frame_%0d: got %h done@%0d rises %0d required %h done@%0d rises 16",
                         i, frame_at(0), done_q[0] - e0, rise_q.size(), f, 33*N);
            end
        end
    endtask

`ifdef SPI_CTRL_READBACK_EN
    task automatic test_readback();
        int e0;
        clear_mon();
        resp_val = 8'h3C;
        send(16'h8422, 1'b0, e0);
        wait_done(0);
        checks++;
        if (rsp_data !== 8'h3C) begin
            errors++;
            $display("FAIL readback_first: got %h required 3c", rsp_data);
        end
        resp_val = 8'hC3;
        send(16'h8533, 1'b0, e0);
        while (cyc < e0 + 131) @(negedge clk);
        checks++;
        if (rsp_data !== 8'h3C) begin
            errors++;
            $display("FAIL readback_hold: got %h required 3c", rsp_data);
        end
        wait_done(1);
        checks++;
        if (rsp_data !== 8'hC3) begin
            errors++;
            $display("FAIL readback_second: got %h required c3", rsp_data);
        end
    endtask
`endif

    initial begin
        ifc.req_valid = 1'b0;
        ifc.req_write = 1'b0;
        ifc.req_addr  = '0;
        ifc.req_data  = '0;
        test_reset();
        test_frame();
        test_back_to_back();
        test_loopback();
        test_reset_mid();
        test_ignore();
        test_random();
`ifdef SPI_CTRL_READBACK_EN
        test_readback();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
